mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences the single shared DMA/host memory port between two requesters: instruction-line fetch (Fetch stage) and FFT data-line load (Memory stage).
- Replaces the combinational address/op mux at CPU top level with a registered request/response controller.
- Drives the downstream port (mem_address, op) and returns per-requester write-enable pulses that capture common_data_bus_in.
- Generates the pipeline stall and a sticky timeout error.

Parameters:
- ADDRW, 32, address width.
- INW, 512, line width in bits. Address low bits log2(INW/8) = 6 are forced to zero.
- TIMEOUT, 1024, maximum cycles in WAIT before abort.
- TOW, 11, width of the timeout counter. Must satisfy TOW ≥ clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- instr_req  in  1  fetch needs an instruction line; held until instr_write_en pulse
- instr_addr  in  ADDRW  fetch line address (PC)
- data_req  in  1  memory stage needs a data line; held until mem_write_en pulse
- data_addr  in  ADDRW  data line address (execute result)
- dma_ready  in  1  downstream accepts the request this cycle
- rd_valid  in  1  returned line valid on common_data_bus_in
- mem_address  out  ADDRW  registered request address, line-aligned
- op  out  2  00 idle, 01 read; 10/11 never driven
- instr_write_en  out  1  one-cycle pulse: fetch captures bus
- mem_write_en  out  1  one-cycle pulse: memory stage captures bus
- stall  out  1  pipeline stall
- busy  out  1  state != IDLE
- timeout_err  out  1  sticky abort flag

Behaviour:
- Reset (synchronous): state=IDLE; mem_address=0; op=00; both write enables=0; owner=DATA; last_grant=INSTR; timeout counter=0; timeout_err=0. Reset mid-transaction aborts immediately, with no pulse. A late rd_valid after reset is ignored.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any request is pending, grant one, latch owner and the aligned address (addr & ~63), and go to ISSUE.
  - Arbitration: a single requester wins. If both request, grant the one not equal to last_grant (alternating). After reset data wins the first tie.
  - last_grant updates at grant.
- ISSUE:
  - op=01, mem_address held.
  - On dma_ready: go to WAIT and clear the counter.
  - If dma_ready and rd_valid occur in the same cycle, go directly to DONE.
  - rd_valid without dma_ready is ignored.
- WAIT:
  - op=00.
  - On rd_valid: go to DONE.
  - Otherwise increment the counter. When counter == TIMEOUT-1 with no rd_valid: set timeout_err, return to IDLE, no pulse. A requester still asserting re-arbitrates.
- DONE:
  - Assert exactly one of instr_write_en/mem_write_en for one cycle, per owner. These are registered outputs, asserted during the DONE cycle.
  - Return to IDLE. The requester deasserts its request the cycle after the pulse.
  - A request still high in the IDLE cycle after DONE is treated as a new request.
- Latency: grant to pulse = 3 cycles minimum, with dma_ready in the first ISSUE cycle and rd_valid on the next cycle.
- rd_valid in IDLE or DONE is ignored.
- stall = instr_req | data_req | busy (combinational). Requests raised during a transaction wait. Address changes while pending are ignored until re-grant.
- op and mem_address are registered. mem_address retains its last value in IDLE.

Decomposition:
- Shared package: state enum (IDLE/ISSUE/WAIT/DONE), op encodings OP_IDLE=2'b00 and OP_READ=2'b01, owner enum (INSTR/DATA), LINE_OFS=6.
- Natural sub-module: rr_arb2, a 2-requester alternating arbiter with last_grant register and grant-enable input.
- Timeout counter and FSM stay in the top level.

Test Plan:
1. instr_req=1, instr_addr=0x0000_0047; dma_ready on first ISSUE cycle; rd_valid one cycle later -> mem_address=0x0000_0040, op=01 for exactly one cycle, instr_write_en pulse 3 cycles after grant, mem_write_en stays 0.
2. instr_req and data_req rise together after reset -> data granted first (mem_write_en). Instr then granted next, and a third simultaneous tie grants data again (alternation).
3. dma_ready held low 5 cycles in ISSUE -> op=01 held 6 cycles, address stable, stall=1 throughout.
4. TIMEOUT=16, no rd_valid -> after 16 WAIT cycles timeout_err=1 (sticky), no write pulse. Held request is re-granted and completes normally with timeout_err still 1.
5. dma_ready and rd_valid asserted in the same ISSUE cycle -> DONE next cycle, pulse 2 cycles after grant.
6. rst asserted during WAIT, then rd_valid arrives -> all outputs at reset values, no pulse, state=IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } owner_e;

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_READ = 2'b01;

  localparam int unsigned LINE_OFS = 6;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes plus the downstream memory port, bundled for the arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDRW = 32
);

  logic             instr_req;
  logic [ADDRW-1:0] instr_addr;
  logic             data_req;
  logic [ADDRW-1:0] data_addr;
  logic             dma_ready;
  logic             rd_valid;
  logic [ADDRW-1:0] mem_address;
  logic [1:0]       op;
  logic             instr_write_en;
  logic             mem_write_en;
  logic             stall;
  logic             busy;
  logic             timeout_err;

  modport slave (
    input  instr_req, instr_addr, data_req, data_addr, dma_ready, rd_valid,
    output mem_address, op, instr_write_en, mem_write_en, stall, busy, timeout_err
  );

  modport master (
    output instr_req, instr_addr, data_req, data_addr, dma_ready, rd_valid,
    input  mem_address, op, instr_write_en, mem_write_en, stall, busy, timeout_err
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-requester alternating arbiter; last_grant advances only when grant_en accepts a grant.
module rr_arb2
  import mem_port_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_instr,
  input  logic   req_data,
  input  logic   grant_en,
  output logic   gnt_valid_c,
  output owner_e gnt_owner_c
);

  owner_e last_grant;

  // On a tie, hand the port to whoever did not get it last time.
  always_comb begin
    gnt_valid_c = req_instr | req_data;
    gnt_owner_c = DATA;
    if (req_instr && req_data) begin
      gnt_owner_c = (last_grant == INSTR) ? DATA : INSTR;
    end else if (req_instr) begin
      gnt_owner_c = INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= INSTR;
    end else if (grant_en && gnt_valid_c) begin
      last_grant <= gnt_owner_c;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Registered request/response controller sharing one memory port between
// instruction fetch and data-line load, with stall and sticky timeout error.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDRW   = 32,
  parameter int unsigned INW     = 512,
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned TOW     = 11
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  localparam logic [ADDRW-1:0] LINE_MASK = ~ADDRW'((1 << LINE_OFS) - 1);

  if (INW / 8 != (1 << LINE_OFS)) begin : g_bad_inw
    $error("mem_port_arbiter: INW inconsistent with LINE_OFS");
  end
  if (TOW < $clog2(TIMEOUT + 1)) begin : g_bad_tow
    $error("mem_port_arbiter: TOW too narrow for TIMEOUT");
  end

  state_e           state, state_n;
  owner_e           owner, owner_n;
  logic [ADDRW-1:0] addr_q, addr_n;
  logic [1:0]       op_q, op_n;
  logic             iwe_q, iwe_n;
  logic             mwe_q, mwe_n;
  logic [TOW-1:0]   cnt, cnt_n;
  logic             err_q, err_n;
  logic             grant_en;
  logic             gnt_valid;
  owner_e           gnt_owner;
  logic [ADDRW-1:0] gnt_addr;

  rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_instr   (bus.instr_req),
    .req_data    (bus.data_req),
    .grant_en    (grant_en),
    .gnt_valid_c (gnt_valid),
    .gnt_owner_c (gnt_owner)
  );

  assign gnt_addr = ((gnt_owner == DATA) ? bus.data_addr : bus.instr_addr) & LINE_MASK;

  // Next-state and next-output logic; registered outputs follow the state being entered.
  always_comb begin
    state_n  = state;
    owner_n  = owner;
    addr_n   = addr_q;
    cnt_n    = cnt;
    err_n    = err_q;
    grant_en = 1'b0;

    case (state)
      IDLE: begin
        if (gnt_valid) begin
          grant_en = 1'b1;
          owner_n  = gnt_owner;
          addr_n   = gnt_addr;
          state_n  = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.dma_ready) begin
          cnt_n   = '0;
          state_n = bus.rd_valid ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (bus.rd_valid) begin
          state_n = DONE;
        end else if (cnt == TOW'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + TOW'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    op_n  = (state_n == ISSUE) ? OP_READ : OP_IDLE;
    iwe_n = (state_n == DONE) && (owner_n == INSTR);
    mwe_n = (state_n == DONE) && (owner_n == DATA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= DATA;
      addr_q <= '0;
      op_q   <= OP_IDLE;
      iwe_q  <= 1'b0;
      mwe_q  <= 1'b0;
      cnt    <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      owner  <= owner_n;
      addr_q <= addr_n;
      op_q   <= op_n;
      iwe_q  <= iwe_n;
      mwe_q  <= mwe_n;
      cnt    <= cnt_n;
      err_q  <= err_n;
    end
  end

  assign bus.mem_address    = addr_q;
  assign bus.op             = op_q;
  assign bus.instr_write_en = iwe_q;
  assign bus.mem_write_en   = mwe_q;
  assign bus.busy           = (state != IDLE);
  assign bus.stall          = bus.instr_req | bus.data_req | (state != IDLE);
  assign bus.timeout_err    = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grants are predicted into a scoreboard
// and popped when the write-enable pulse appears.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int unsigned ADDRW = 32;
  localparam int unsigned TMO   = 16;

  typedef struct packed {
    logic             is_data;
    logic [ADDRW-1:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  logic last_data;

  mem_port_arbiter_if #(.ADDRW(ADDRW)) bus ();

  mem_port_arbiter #(
    .ADDRW   (ADDRW),
    .INW     (512),
    .TIMEOUT (TMO),
    .TOW     (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_op"},   32'(bus.op), 32'(OP_IDLE));
    chk({tag, "_addr"}, bus.mem_address, 32'h0);
    chk({tag, "_iwe"},  32'(bus.instr_write_en), 32'd0);
    chk({tag, "_mwe"},  32'(bus.mem_write_en), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_err"},  32'(bus.timeout_err), 32'd0);
  endtask

  // Predict the winner from the current requests and push it.
  task automatic grant_model();
    exp_t e;
    if (bus.instr_req && bus.data_req) e.is_data = !last_data;
    else                               e.is_data = bus.data_req;
    e.addr    = (e.is_data ? bus.data_addr : bus.instr_addr) & 32'hFFFF_FFC0;
    last_data = e.is_data;
    sb.push_back(e);
  endtask

  task automatic check_pulse(input string tag, output logic is_data);
    exp_t e;
    is_data = 1'b0;
    chk({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e       = sb.pop_front();
      is_data = e.is_data;
      chk({tag, "_iwe"},  32'(bus.instr_write_en), 32'(!e.is_data));
      chk({tag, "_mwe"},  32'(bus.mem_write_en), 32'(e.is_data));
      chk({tag, "_addr"}, bus.mem_address, e.addr);
    end
  endtask

  // One full transaction starting from an IDLE negedge with a request pending.
  task automatic run_xact(input string tag, input int ready_delay, input bit same,
                          input int wait_cycles, input bit noise);
    exp_t e;
    logic is_data;
    grant_model();
    e = sb[$];
    tick();
    for (int i = 0; i < ready_delay; i++) begin
      chk({tag, "_iss_op"},    32'(bus.op), 32'(OP_READ));
      chk({tag, "_iss_addr"},  bus.mem_address, e.addr);
      chk({tag, "_iss_stall"}, 32'(bus.stall), 32'd1);
      if (noise) begin
        bus.rd_valid   = 1'b1;
        bus.instr_addr = bus.instr_addr ^ 32'h0000_1000;
        bus.data_addr  = bus.data_addr ^ 32'h0000_1000;
      end
      tick();
    end
    chk({tag, "_rdy_op"},   32'(bus.op), 32'(OP_READ));
    chk({tag, "_rdy_addr"}, bus.mem_address, e.addr);
    bus.dma_ready = 1'b1;
    bus.rd_valid  = same;
    tick();
    bus.dma_ready = 1'b0;
    bus.rd_valid  = 1'b0;
    if (!same) begin
      chk({tag, "_wait_op"},   32'(bus.op), 32'(OP_IDLE));
      chk({tag, "_wait_busy"}, 32'(bus.busy), 32'd1);
      for (int i = 0; i < wait_cycles; i++) tick();
      bus.rd_valid = 1'b1;
      tick();
      bus.rd_valid = 1'b0;
    end
    check_pulse(tag, is_data);
    if (is_data) bus.data_req = 1'b0;
    else         bus.instr_req = 1'b0;
    tick();
    chk({tag, "_post_iwe"},  32'(bus.instr_write_en), 32'd0);
    chk({tag, "_post_mwe"},  32'(bus.mem_write_en), 32'd0);
    chk({tag, "_post_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_post_addr"}, bus.mem_address, e.addr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    bus.instr_req  = 1'b0;
    bus.instr_addr = '0;
    bus.data_req   = 1'b0;
    bus.data_addr  = '0;
    bus.dma_ready  = 1'b0;
    bus.rd_valid   = 1'b0;
    last_data      = 1'b0;
    tick();
    tick();
    check_reset("rst");
    rst = 1'b0;

    // Single fetch, minimum latency
    bus.instr_req  = 1'b1;
    bus.instr_addr = 32'h0000_0047;
    run_xact("t1", 0, 1'b0, 0, 1'b0);

    // Reset during WAIT, then a late rd_valid
    bus.instr_req  = 1'b1;
    bus.instr_addr = 32'h0000_2345;
    tick();
    bus.dma_ready = 1'b1;
    tick();
    bus.dma_ready = 1'b0;
    chk("t6_wait_busy", 32'(bus.busy), 32'd1);
    rst           = 1'b1;
    bus.instr_req = 1'b0;
    tick();
    rst          = 1'b0;
    bus.rd_valid = 1'b1;
    tick();
    bus.rd_valid = 1'b0;
    check_reset("t6");
    last_data = 1'b0;

    // Ties alternate, data first after reset
    bus.instr_addr = 32'h0000_4010;
    bus.data_addr  = 32'h0000_8080;
    bus.instr_req  = 1'b1;
    bus.data_req   = 1'b1;
    run_xact("t2a", 0, 1'b0, 1, 1'b0);
    run_xact("t2b", 0, 1'b0, 0, 1'b0);
    bus.instr_addr = 32'h0000_C0FF;
    bus.data_addr  = 32'h0001_0001;
    bus.instr_req  = 1'b1;
    bus.data_req   = 1'b1;
    run_xact("t2c", 0, 1'b0, 0, 1'b0);
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h0002_007F;
    run_xact("t2d", 0, 1'b0, 0, 1'b0);
    run_xact("t2e", 0, 1'b0, 0, 1'b0);

    // Long ISSUE with stray rd_valid and address churn
    bus.instr_req  = 1'b1;
    bus.instr_addr = 32'h0001_00FF;
    run_xact("t3", 5, 1'b0, 2, 1'b1);

    // dma_ready and rd_valid together
    bus.data_req  = 1'b1;
    bus.data_addr = 32'h1234_5678;
    run_xact("t5", 0, 1'b1, 0, 1'b0);

    // Timeout abort, then re-grant of the held request
    bus.instr_req  = 1'b1;
    bus.instr_addr = 32'h0000_0A10;
    grant_model();
    tick();
    chk("t4_iss_op", 32'(bus.op), 32'(OP_READ));
    bus.dma_ready = 1'b1;
    tick();
    bus.dma_ready = 1'b0;
    for (int i = 0; i < int'(TMO); i++) begin
      chk("t4_wait_busy", 32'(bus.busy), 32'd1);
      chk("t4_wait_err",  32'(bus.timeout_err), 32'd0);
      tick();
    end
    chk("t4_abort_err",  32'(bus.timeout_err), 32'd1);
    chk("t4_abort_busy", 32'(bus.busy), 32'd0);
    chk("t4_abort_iwe",  32'(bus.instr_write_en), 32'd0);
    chk("t4_abort_mwe",  32'(bus.mem_write_en), 32'd0);
    void'(sb.pop_back());
    run_xact("t4_regrant", 0, 1'b0, 1, 1'b0);
    chk("t4_err_sticky", 32'(bus.timeout_err), 32'd1);
    tick();
    tick();
    chk("t4_err_sticky2", 32'(bus.timeout_err), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
